// File: rtl/calc1_responder_pkg.sv
// Shared calc1 definitions: command/response codes, widths, pipeline stage
// types and the ALU evaluation function.
package calc1_defs;

  localparam int DATA_W    = 32;
  localparam int CMD_W     = 4;
  localparam int NUM_PORTS = 4;

  localparam logic [CMD_W-1:0] CMD_NOP = 4'd0;
  localparam logic [CMD_W-1:0] CMD_ADD = 4'd1;
  localparam logic [CMD_W-1:0] CMD_SUB = 4'd2;
  localparam logic [CMD_W-1:0] CMD_LSH = 4'd5;
  localparam logic [CMD_W-1:0] CMD_RSH = 4'd6;

  localparam logic [1:0] RESP_NONE = 2'd0;
  localparam logic [1:0] RESP_OK   = 2'd1;
  localparam logic [1:0] RESP_OVF  = 2'd2;
  localparam logic [1:0] RESP_INV  = 2'd3;

  typedef struct packed {
    logic              valid;
    logic [1:0]        port;
    logic [CMD_W-1:0]  cmd;
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
  } gnt_stage_t;

  typedef struct packed {
    logic              valid;
    logic [1:0]        port;
    logic [1:0]        resp;
    logic [DATA_W-1:0] data;
  } resp_stage_t;

  function automatic resp_stage_t alu(input gnt_stage_t g);
    resp_stage_t     r;
    logic [DATA_W:0] sum;
    r.valid = g.valid;
    r.port  = g.port;
    r.resp  = RESP_OK;
    r.data  = '0;
    sum     = {1'b0, g.op1} + {1'b0, g.op2};
    case (g.cmd)
      CMD_ADD: if (sum[DATA_W]) r.resp = RESP_OVF; else r.data = sum[DATA_W-1:0];
      CMD_SUB: if (g.op2 > g.op1) r.resp = RESP_OVF; else r.data = g.op1 - g.op2;
      // shift amount is the low five bits of op2
      CMD_LSH: r.data = g.op1 << g.op2[4:0];
      CMD_RSH: r.data = g.op1 >> g.op2[4:0];
      default: r.resp = RESP_INV;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/calc1_responder_if.sv
// Four-port calc1 request/response bundle; bit 0 of every field is the MSB.
interface calc1_responder_if;
  import calc1_defs::*;

  logic [0:CMD_W-1]  req1_cmd_in,  req2_cmd_in,  req3_cmd_in,  req4_cmd_in;
  logic [0:DATA_W-1] req1_data_in, req2_data_in, req3_data_in, req4_data_in;
  logic [0:1]        out_resp1,    out_resp2,    out_resp3,    out_resp4;
  logic [0:DATA_W-1] out_data1,    out_data2,    out_data3,    out_data4;

  modport master (
    output req1_cmd_in, req2_cmd_in, req3_cmd_in, req4_cmd_in,
    output req1_data_in, req2_data_in, req3_data_in, req4_data_in,
    input  out_resp1, out_resp2, out_resp3, out_resp4,
    input  out_data1, out_data2, out_data3, out_data4
  );

  modport slave (
    input  req1_cmd_in, req2_cmd_in, req3_cmd_in, req4_cmd_in,
    input  req1_data_in, req2_data_in, req3_data_in, req4_data_in,
    output out_resp1, out_resp2, out_resp3, out_resp4,
    output out_data1, out_data2, out_data3, out_data4
  );

endinterface

// File: rtl/calc1_responder_port_ctrl.sv
// Per-port capture FSM: grabs cmd/op1 then op2, requests the ALU, and holds
// off new commands until its response has been registered.
//   state  | meaning
//   IDLE   | waiting for a nonzero command
//   OP2    | next data word is operand 2
//   PEND   | operands captured, requesting arbiter grant
//   BUSY   | granted, waiting for response to be registered
module calc1_port_ctrl
  import calc1_defs::*;
(
  input  logic              c_clk,
  input  logic              reset,
  input  logic [CMD_W-1:0]  cmd_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              grant,
  input  logic              done,
  output logic              pend,
  output logic [CMD_W-1:0]  cmd,
  output logic [DATA_W-1:0] op1,
  output logic [DATA_W-1:0] op2
);

  typedef enum logic [1:0] {S_IDLE, S_OP2, S_PEND, S_BUSY} state_t;
  state_t state;

  always_ff @(posedge c_clk) begin
    if (reset) begin
      state <= S_IDLE;
      pend  <= 1'b0;
      cmd   <= CMD_NOP;
      op1   <= '0;
      op2   <= '0;
    end else begin
      case (state)
        S_IDLE: if (cmd_in != CMD_NOP) begin
          cmd   <= cmd_in;
          op1   <= data_in;
          state <= S_OP2;
        end
        S_OP2: begin
          op2   <= data_in;
          pend  <= 1'b1;
          state <= S_PEND;
        end
        S_PEND: if (grant) begin
          pend  <= 1'b0;
          state <= S_BUSY;
        end
        S_BUSY: if (done) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/calc1_responder.sv
// calc1 responder: four capture FSMs feeding a round-robin arbitrated ALU
// and a response pipeline of 1+EXTRA_DELAY registered stages.
module calc1_responder
  import calc1_defs::*;
#(
  parameter int EXTRA_DELAY = 0
) (
  input logic               c_clk,
  input logic               reset,
  calc1_responder_if.slave  bus
);

  logic [CMD_W-1:0]     cmd_in   [NUM_PORTS];
  logic [DATA_W-1:0]    data_in  [NUM_PORTS];
  logic [CMD_W-1:0]     port_cmd [NUM_PORTS];
  logic [DATA_W-1:0]    port_op1 [NUM_PORTS];
  logic [DATA_W-1:0]    port_op2 [NUM_PORTS];
  logic [1:0]           resp_o   [NUM_PORTS];
  logic [DATA_W-1:0]    data_o   [NUM_PORTS];
  logic [NUM_PORTS-1:0] pend, grant, done;

  assign cmd_in[0]  = bus.req1_cmd_in;
  assign cmd_in[1]  = bus.req2_cmd_in;
  assign cmd_in[2]  = bus.req3_cmd_in;
  assign cmd_in[3]  = bus.req4_cmd_in;
  assign data_in[0] = bus.req1_data_in;
  assign data_in[1] = bus.req2_data_in;
  assign data_in[2] = bus.req3_data_in;
  assign data_in[3] = bus.req4_data_in;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    calc1_port_ctrl u_port_ctrl (
      .c_clk   (c_clk),
      .reset   (reset),
      .cmd_in  (cmd_in[p]),
      .data_in (data_in[p]),
      .grant   (grant[p]),
      .done    (done[p]),
      .pend    (pend[p]),
      .cmd     (port_cmd[p]),
      .op1     (port_op1[p]),
      .op2     (port_op2[p])
    );
  end

  logic [1:0] ptr, gnt_idx, idx;
  logic       gnt_any;

  // first pending port at or after the pointer wins
  always_comb begin
    grant   = '0;
    gnt_idx = ptr;
    gnt_any = 1'b0;
    idx     = ptr;
    for (int i = 0; i < NUM_PORTS; i++) begin
      idx = ptr + 2'(i);
      if (!gnt_any && pend[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = idx;
      end
    end
    if (gnt_any) grant[gnt_idx] = 1'b1;
  end

  gnt_stage_t  gnt_q;
  resp_stage_t alu_out, feed;
  resp_stage_t pipe [0:EXTRA_DELAY];

  assign alu_out = alu(gnt_q);

  always_ff @(posedge c_clk) begin
    if (reset) begin
      ptr     <= 2'd0;
      gnt_q   <= '0;
      pipe[0] <= '0;
    end else begin
      if (gnt_any) ptr <= gnt_idx + 2'd1;
      gnt_q   <= '{valid: gnt_any, port: gnt_idx, cmd: port_cmd[gnt_idx],
                   op1: port_op1[gnt_idx], op2: port_op2[gnt_idx]};
      pipe[0] <= alu_out;
    end
  end

  for (genvar k = 1; k <= EXTRA_DELAY; k++) begin : g_delay
    always_ff @(posedge c_clk) begin
      if (reset) pipe[k] <= '0;
      else       pipe[k] <= pipe[k-1];
    end
  end

  // the stage about to load the output register tells its port it is done
  if (EXTRA_DELAY == 0) begin : g_feed_alu
    assign feed = alu_out;
  end else begin : g_feed_pipe
    assign feed = pipe[EXTRA_DELAY-1];
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_out
    logic hit;
    assign done[p]   = feed.valid && (feed.port == 2'(p));
    assign hit       = pipe[EXTRA_DELAY].valid && (pipe[EXTRA_DELAY].port == 2'(p));
    assign resp_o[p] = hit ? pipe[EXTRA_DELAY].resp : RESP_NONE;
    assign data_o[p] = hit ? pipe[EXTRA_DELAY].data : '0;
  end

  assign bus.out_resp1 = resp_o[0];
  assign bus.out_resp2 = resp_o[1];
  assign bus.out_resp3 = resp_o[2];
  assign bus.out_resp4 = resp_o[3];
  assign bus.out_data1 = data_o[0];
  assign bus.out_data2 = data_o[1];
  assign bus.out_data3 = data_o[2];
  assign bus.out_data4 = data_o[3];

endmodule

// File: tb/tb_calc1_responder.sv
// Scoreboard bench for calc1_responder: expectations queued at command
// issue, matched against responses sampled on the falling edge.
module tb_calc1_responder;

  localparam int ED = 0;

  logic c_clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;

  typedef struct {
    int          port;
    logic [1:0]  resp;
    logic [31:0] data;
    int          due;
  } exp_t;
  exp_t sbq[$];

  calc1_responder_if bus();

  calc1_responder #(.EXTRA_DELAY(ED)) dut (
    .c_clk (c_clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 c_clk = ~c_clk;
  always @(posedge c_clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1, "timeout");
  end

  function automatic logic [1:0] get_resp(int p);
    case (p)
      1: return bus.out_resp1;
      2: return bus.out_resp2;
      3: return bus.out_resp3;
      default: return bus.out_resp4;
    endcase
  endfunction

  function automatic logic [31:0] get_data(int p);
    case (p)
      1: return bus.out_data1;
      2: return bus.out_data2;
      3: return bus.out_data3;
      default: return bus.out_data4;
    endcase
  endfunction

  task automatic drive_port(int p, logic [3:0] c, logic [31:0] d);
    case (p)
      1: begin bus.req1_cmd_in = c; bus.req1_data_in = d; end
      2: begin bus.req2_cmd_in = c; bus.req2_data_in = d; end
      3: begin bus.req3_cmd_in = c; bus.req3_data_in = d; end
      default: begin bus.req4_cmd_in = c; bus.req4_data_in = d; end
    endcase
  endtask

  // independent reference for the ALU using wide arithmetic
  task automatic model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                       output logic [1:0] r, output logic [31:0] d);
    logic [63:0] wide;
    r = 2'd1;
    d = 32'd0;
    case (c)
      4'd1: begin
        wide = {32'd0, a} + {32'd0, b};
        if (wide > 64'h0000_0000_FFFF_FFFF) r = 2'd2; else d = wide[31:0];
      end
      4'd2: if (b > a) r = 2'd2; else d = a - b;
      4'd5: d = a << (b % 32);
      4'd6: d = a >> (b % 32);
      default: r = 2'd3;
    endcase
  endtask

  always @(negedge c_clk) begin
    if (mon_en) begin
      for (int p = 1; p <= 4; p++) begin
        logic [1:0]  r;
        logic [31:0] d;
        int          hit;
        r = get_resp(p);
        d = get_data(p);
        n_checks++;
        if (r !== 2'd0) begin
          hit = -1;
          foreach (sbq[i]) if (hit < 0 && sbq[i].port == p) hit = i;
          if (hit < 0) begin
            n_fail++;
            $display("FAIL unexpected_resp port%0d cyc %0d: resp %0d data %h, required no response",
                     p, cyc, r, d);
          end else begin
            if (r !== sbq[hit].resp || d !== sbq[hit].data || cyc != sbq[hit].due) begin
              n_fail++;
              $display("FAIL resp_match port%0d: got resp %0d data %h at cyc %0d, required resp %0d data %h at cyc %0d",
                       p, r, d, cyc, sbq[hit].resp, sbq[hit].data, sbq[hit].due);
            end
            sbq.delete(hit);
          end
        end else if (d !== 32'd0) begin
          n_fail++;
          $display("FAIL idle_data port%0d cyc %0d: data %h with resp 0, required 0", p, cyc, d);
        end
      end
    end
  end

  task automatic apply_reset();
    reset = 1'b1;
    for (int p = 1; p <= 4; p++) drive_port(p, 4'd0, 32'd0);
    repeat (3) @(posedge c_clk);
    #1;
  endtask

  // issue one command; response expected lat cycles after the cmd edge
  task automatic send(int p, logic [3:0] c, logic [31:0] a, logic [31:0] b,
                      logic [1:0] r, logic [31:0] d, int lat);
    drive_port(p, c, a);
    @(posedge c_clk); #1;
    sbq.push_back('{port: p, resp: r, data: d, due: cyc + lat});
    drive_port(p, 4'd0, b);
    @(posedge c_clk); #1;
    drive_port(p, 4'd0, 32'd0);
  endtask

  task automatic wait_empty();
    for (int k = 0; k < 40 && sbq.size() != 0; k++) @(posedge c_clk);
    repeat (6) @(posedge c_clk);
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    for (int p = 1; p <= 4; p++) begin
      n_checks += 2;
      if (get_resp(p) !== 2'd0) begin
        n_fail++;
        $display("FAIL reset_resp port%0d: got %0d, required 0", p, get_resp(p));
      end
      if (get_data(p) !== 32'd0) begin
        n_fail++;
        $display("FAIL reset_data port%0d: got %h, required 0", p, get_data(p));
      end
    end
    reset  = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic test_add();
    send(1, 4'd1, 32'd255, 32'd1, 2'd1, 32'd256, 3 + ED);
    wait_empty();
    n_checks++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL add_drain: %0d outstanding, required 0", sbq.size());
      sbq.delete();
    end
  endtask

  task automatic test_overflow();
    send(2, 4'd2, 32'd1, 32'd100, 2'd2, 32'd0, 3 + ED);
    wait_empty();
    send(2, 4'd1, 32'hFFFF_FFFF, 32'd1, 2'd2, 32'd0, 3 + ED);
    wait_empty();
    n_checks++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL overflow_drain: %0d outstanding, required 0", sbq.size());
      sbq.delete();
    end
  endtask

  task automatic test_shift();
    send(1, 4'd5, 32'd1, 32'd4, 2'd1, 32'h10, 3 + ED);
    wait_empty();
    send(1, 4'd6, 32'h8000_0000, 32'd31, 2'd1, 32'd1, 3 + ED);
    wait_empty();
    send(1, 4'd5, 32'd1, 32'd33, 2'd1, 32'd2, 3 + ED);
    wait_empty();
    n_checks++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL shift_drain: %0d outstanding, required 0", sbq.size());
      sbq.delete();
    end
  endtask

  task automatic test_simultaneous();
    apply_reset();
    reset = 1'b0;
    drive_port(3, 4'd1, 32'd1);
    drive_port(4, 4'd1, 32'd2);
    @(posedge c_clk); #1;
    sbq.push_back('{port: 3, resp: 2'd1, data: 32'd5,  due: cyc + 3 + ED});
    sbq.push_back('{port: 4, resp: 2'd1, data: 32'd10, due: cyc + 4 + ED});
    drive_port(3, 4'd0, 32'd4);
    drive_port(4, 4'd0, 32'd8);
    @(posedge c_clk); #1;
    drive_port(3, 4'd0, 32'd0);
    drive_port(4, 4'd0, 32'd0);
    wait_empty();
    n_checks++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL simultaneous_drain: %0d outstanding, required 0", sbq.size());
      sbq.delete();
    end
  endtask

  task automatic test_invalid();
    drive_port(4, 4'd3, 32'd7);
    @(posedge c_clk); #1;
    sbq.push_back('{port: 4, resp: 2'd3, data: 32'd0, due: cyc + 3 + ED});
    drive_port(4, 4'd1, 32'd9);
    @(posedge c_clk); #1;
    drive_port(4, 4'd2, 32'd5);
    @(posedge c_clk); #1;
    drive_port(4, 4'd0, 32'd0);
    wait_empty();
    n_checks++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL invalid_drain: %0d outstanding, required 0", sbq.size());
      sbq.delete();
    end
  endtask

  task automatic test_reset_midop();
    drive_port(1, 4'd1, 32'd10);
    @(posedge c_clk); #1;
    drive_port(1, 4'd0, 32'd20);
    @(posedge c_clk); #1;
    drive_port(1, 4'd0, 32'd0);
    reset = 1'b1;
    repeat (2) @(posedge c_clk);
    #1;
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      n_checks++;
      if (get_resp(1) !== 2'd0 || get_data(1) !== 32'd0) begin
        n_fail++;
        $display("FAIL midreset_quiet: resp %0d data %h, required 0/0", get_resp(1), get_data(1));
      end
      @(posedge c_clk); #1;
    end
    send(1, 4'd1, 32'd3, 32'd4, 2'd1, 32'd7, 3 + ED);
    wait_empty();
    n_checks++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL midreset_fresh: %0d outstanding, required 0", sbq.size());
      sbq.delete();
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  ops [6];
    logic [3:0]  c;
    logic [31:0] a, b, d;
    logic [1:0]  r;
    ops[0] = 4'd1; ops[1] = 4'd2; ops[2] = 4'd5;
    ops[3] = 4'd6; ops[4] = 4'd3; ops[5] = 4'd12;
    for (int n = 0; n < 12; n++) begin
      c = ops[$urandom_range(0, 5)];
      a = $urandom;
      b = (n % 3 == 0) ? $urandom : 32'($urandom_range(0, 40));
      model(c, a, b, r, d);
      drive_port(2, c, a);
      @(posedge c_clk); #1;
      sbq.push_back('{port: 2, resp: r, data: d, due: cyc + 3 + ED});
      drive_port(2, 4'd0, b);
      @(posedge c_clk); #1;
      drive_port(2, 4'd0, 32'd0);
      repeat (2 + ED) @(posedge c_clk);
      #1;
    end
    wait_empty();
    n_checks++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL back_to_back_drain: %0d outstanding, required 0", sbq.size());
      sbq.delete();
    end
  endtask

  initial begin
    for (int p = 1; p <= 4; p++) drive_port(p, 4'd0, 32'd0);
    @(posedge c_clk); #1;
    test_reset();
    test_add();
    test_overflow();
    test_shift();
    test_simultaneous();
    test_invalid();
    test_reset_midop();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
